simon_round_sequencer: RTL
==========================

Name: simon_round_sequencer

Overview:
- Top-level game controller for the Simon Says datapath.
- Plays the first `len` entries of the packed colour pattern on the LED outputs, then collects the same number of player presses and grades each one as right, wrong or timeout.
- Grows the round length by one after every fully correct round, up to a win.
- Sits between the tick prescaler, the button debouncer/encoder, the pattern source and the LED/score display.

Parameters:
- MAX_LEN, 16: longest sequence; reaching it correctly is a win.
- SHOW_TICKS, 4: ticks each colour is lit during playback.
- GAP_TICKS, 2: dark ticks after each lit colour.
- TIMEOUT_TICKS, 7: ticks allowed between presses in INPUT.
- LW, $clog2(MAX_LEN+1): width of length/index fields (derived; do not override).

Ports:
- clk  input  1  system clock.
- reset  input  1  reset, asynchronous, active-high.
- tick  input  1  one-cycle enable from prescaler; all time counting uses it.
- start  input  1  begin a new game (level pulse, sampled each clk).
- colors  input  2*MAX_LEN  pattern; entry i = colors[2*i+1:2*i]; held stable during a game.
- btn_valid  input  1  one-cycle pulse: player pressed a button.
- btn_color  input  2  colour of that press, valid with btn_valid.
- led_on  output  1  playback LED enable.
- led_color  output  2  colour being played.
- result  output  2  00 waiting, 01 right, 10 wrong, 11 timeout.
- rounds_won  output  LW  completed rounds in current game.
- busy  output  1  high in SHOW, GAP, INPUT.
- win  output  1  high in WIN.

Behaviour:
- Reset (async, any state) returns the block to:
  - state IDLE, len=1, idx=0, tcnt=0.
  - Outputs: led_on=0, led_color=00, result=00, rounds_won=0, busy=0, win=0.
- All outputs are registered. led_color=colors[idx] while in SHOW, else 00.
- tcnt counts ticks within a state and clears on every state change.
- "Expires" means tick=1 and tcnt==N-1; the transition happens on that same clk edge. SHOW therefore lasts exactly SHOW_TICKS ticks.
- IDLE / OVER / WIN:
  - start=1 -> SHOW with len=1, idx=0, result=00, rounds_won=0.
  - start is ignored in SHOW, GAP and INPUT.
- SHOW: led_on=1. On expiry of SHOW_TICKS -> GAP.
- GAP: led_on=0. On expiry of GAP_TICKS:
  - if idx==len-1 -> INPUT, idx=0;
  - else idx+1 -> SHOW.
- INPUT: btn_valid with btn_color==colors[idx] is a correct press; result=01, tcnt=0.
  - If idx<len-1: idx+1.
  - If idx==len-1 and len==MAX_LEN: -> WIN, rounds_won+1.
  - If idx==len-1 and len<MAX_LEN: len+1, idx=0, rounds_won+1, -> SHOW.
- INPUT: btn_valid with a mismatched colour -> OVER, result=10.
- INPUT: no press and TIMEOUT_TICKS expires -> OVER, result=11.
- Press and timeout expiry on the same edge: the press wins.
- btn_valid outside INPUT is ignored; no result change.
- result holds its value until a new start or reset.
- len never exceeds MAX_LEN. idx never exceeds len-1.
- rounds_won saturates at MAX_LEN.
- tick=0 forever: the FSM stalls in timed states. It still accepts presses in INPUT.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, SHOW, GAP, INPUT, OVER, WIN;
  - result codes RES_WAIT=00, RES_RIGHT=01, RES_WRONG=10, RES_TIMEOUT=11;
  - colour constants, 2-bit.
- One sub-module is natural: seq_tick_timer. It is a loadable tick counter with a clear input and an expired output compared against a selectable limit of SHOW_TICKS, GAP_TICKS or TIMEOUT_TICKS.
- The FSM and the index/length registers stay in the top module.

Test Plan:
Bench config: MAX_LEN=2, SHOW_TICKS=2, GAP_TICKS=1, TIMEOUT_TICKS=3, tick=1 every cycle, colors entry0=10, entry1=01.
- Reset mid-SHOW (assert asynchronously between edges) -> all outputs reach their reset values immediately; IDLE; start is then required to play again.
- start pulse -> led_on=1 with led_color=10 for exactly 2 cycles, then led_on=0 for 1 cycle; INPUT entered with busy=1, result=00.
- In round 1, press 10 -> result=01, rounds_won=1; playback shows 10 (2 cycles), gap, 01 (2 cycles), gap.
- In round 2, press 10 then 01 -> WIN, win=1, rounds_won=2, busy=0; a later btn_valid changes nothing.
- In round 1 INPUT, press 11 -> OVER, result=10. Idle 3 cycles in INPUT instead -> result=11. Press on the timeout edge -> graded as a press, not a timeout.
- In OVER, start -> len=1, result=00, rounds_won=0, playback restarts with 10.

Source files
------------

// File: rtl/simon_round_sequencer_pkg.sv
// Shared state, result and colour definitions for the Simon Says round sequencer.
package simon_round_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShow,
    StGap,
    StInput,
    StOver,
    StWin
  } state_e;

  typedef enum logic [1:0] {
    LimShow,
    LimGap,
    LimTimeout
  } limit_sel_e;

  localparam logic [1:0] RES_WAIT    = 2'b00;
  localparam logic [1:0] RES_RIGHT   = 2'b01;
  localparam logic [1:0] RES_WRONG   = 2'b10;
  localparam logic [1:0] RES_TIMEOUT = 2'b11;

  localparam logic [1:0] COLOR_RED    = 2'b00;
  localparam logic [1:0] COLOR_GREEN  = 2'b01;
  localparam logic [1:0] COLOR_BLUE   = 2'b10;
  localparam logic [1:0] COLOR_YELLOW = 2'b11;

  // Value driven on led_color whenever the LED is dark.
  localparam logic [1:0] LED_DARK = 2'b00;

  function automatic logic is_busy(input state_e s);
    return s inside {StShow, StGap, StInput};
  endfunction

endpackage

// File: rtl/seq_tick_timer.sv
// Tick counter for the sequencer's timed states; flags the tick on which the selected
// limit is reached so the caller can change state on that same edge.
module seq_tick_timer
  import simon_round_sequencer_pkg::*;
#(
  parameter int unsigned SHOW_TICKS    = 4,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_i,
  input  logic       clear_i,
  input  limit_sel_e limit_sel_i,
  output logic       expired_o
);

  localparam int unsigned MaxA     = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned MaxTicks = (MaxA > TIMEOUT_TICKS) ? MaxA : TIMEOUT_TICKS;
  localparam int unsigned CW       = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] limit_m1;

  always_comb begin
    case (limit_sel_i)
      LimShow:    limit_m1 = CW'(SHOW_TICKS - 1);
      LimGap:     limit_m1 = CW'(GAP_TICKS - 1);
      default:    limit_m1 = CW'(TIMEOUT_TICKS - 1);
    endcase
  end

  // Clear has priority so a state change restarts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired_o = tick_i && (cnt_q == limit_m1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/simon_round_sequencer.sv
// Simon Says game controller: plays the first len pattern entries, grades the player's
// presses, and grows the round by one entry after every fully correct round.
module simon_round_sequencer
  import simon_round_sequencer_pkg::*;
#(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned SHOW_TICKS    = 4,
  parameter int unsigned GAP_TICKS     = 2,
  parameter int unsigned TIMEOUT_TICKS = 7,
  parameter int unsigned LW            = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 start,
  input  logic [2*MAX_LEN-1:0] colors,
  input  logic                 btn_valid,
  input  logic [1:0]           btn_color,
  output logic                 led_on,
  output logic [1:0]           led_color,
  output logic [1:0]           result,
  output logic [LW-1:0]        rounds_won,
  output logic                 busy,
  output logic                 win
);

  localparam logic [LW-1:0] LenOne = LW'(1);
  localparam logic [LW-1:0] LenMax = LW'(MAX_LEN);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] rounds_q, rounds_d;
  logic [1:0]    result_q, result_d;
  logic [1:0]    led_color_q, led_color_d;
  logic          led_on_q, led_on_d;
  logic          busy_q, busy_d;
  logic          win_q, win_d;

  logic          t_clear;
  logic          t_expired;
  limit_sel_e    limit_sel;
  logic [1:0]    cur_color;
  logic [1:0]    next_color;
  logic          last_idx;

  assign cur_color  = 2'(colors >> {idx_q, 1'b0});
  assign next_color = 2'(colors >> {idx_d, 1'b0});
  assign last_idx   = (idx_q == len_q - LenOne);

  seq_tick_timer #(
    .SHOW_TICKS   (SHOW_TICKS),
    .GAP_TICKS    (GAP_TICKS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .tick_i     (tick),
    .clear_i    (t_clear),
    .limit_sel_i(limit_sel),
    .expired_o  (t_expired)
  );

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    rounds_d  = rounds_q;
    result_d  = result_q;
    t_clear   = 1'b0;
    limit_sel = LimShow;

    unique case (state_q)
      StIdle, StOver, StWin: begin
        t_clear = 1'b1;
        if (start) begin
          state_d  = StShow;
          len_d    = LenOne;
          idx_d    = '0;
          rounds_d = '0;
          result_d = RES_WAIT;
        end
      end
      StShow: begin
        limit_sel = LimShow;
        if (t_expired) begin
          state_d = StGap;
        end
      end
      StGap: begin
        limit_sel = LimGap;
        if (t_expired) begin
          if (last_idx) begin
            state_d = StInput;
            idx_d   = '0;
          end else begin
            state_d = StShow;
            idx_d   = idx_q + LenOne;
          end
        end
      end
      StInput: begin
        limit_sel = LimTimeout;
        // A press on the expiry edge is graded as a press.
        if (btn_valid) begin
          if (btn_color == cur_color) begin
            result_d = RES_RIGHT;
            t_clear  = 1'b1;
            if (!last_idx) begin
              idx_d = idx_q + LenOne;
            end else begin
              rounds_d = (rounds_q == LenMax) ? rounds_q : rounds_q + LenOne;
              if (len_q == LenMax) begin
                state_d = StWin;
              end else begin
                state_d = StShow;
                len_d   = len_q + LenOne;
                idx_d   = '0;
              end
            end
          end else begin
            state_d  = StOver;
            result_d = RES_WRONG;
          end
        end else if (t_expired) begin
          state_d  = StOver;
          result_d = RES_TIMEOUT;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_d != state_q) begin
      t_clear = 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    led_on_d    = (state_d == StShow);
    led_color_d = led_on_d ? next_color : LED_DARK;
    busy_d      = is_busy(state_d);
    win_d       = (state_d == StWin);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      len_q       <= LenOne;
      idx_q       <= '0;
      rounds_q    <= '0;
      result_q    <= RES_WAIT;
      led_on_q    <= 1'b0;
      led_color_q <= LED_DARK;
      busy_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      rounds_q    <= rounds_d;
      result_q    <= result_d;
      led_on_q    <= led_on_d;
      led_color_q <= led_color_d;
      busy_q      <= busy_d;
      win_q       <= win_d;
    end
  end

  assign led_on     = led_on_q;
  assign led_color  = led_color_q;
  assign result     = result_q;
  assign rounds_won = rounds_q;
  assign busy       = busy_q;
  assign win        = win_q;

endmodule
